pe_xbar_bus_ecc_dec_pipe: RTL and testbench

Parametrised, registered successor to the PE-to-XBAR bus ECC stripper.
- Request path: decodes and corrects SECDED-protected write data from the PE side, then forwards the request through a one-entry pipeline register to the 32/64-bit XBAR side.
- Response path: re-encodes read data with SECDED.
- Uncorrectable writes are dropped and answered locally with an error response.
- Correctable and uncorrectable events are counted.
- Sits between the PE port and the XBAR inside the cluster's ECC-protected interconnect.

---
 rtl/pe_xbar_bus_ecc_dec_pipe.sv | 265 ++++++++++++++++++++++++++
 tb/tb_pe_xbar_bus_ecc_dec_pipe.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_xbar_bus_ecc_dec_pipe.sv
// PE-to-XBAR bridge. Write data is SECDED-corrected into a one-entry request register.
// Read data is SECDED-encoded on the way back. Uncorrectable writes are answered locally.
module pe_xbar_bus_ecc_dec_pipe #(
    parameter  int unsigned DataWidth = 32,
    parameter  int unsigned AddrWidth = 32,
    parameter  int unsigned IdWidth   = 5,
    parameter  int unsigned CntWidth  = 16,
    localparam int unsigned EccWidth  = (DataWidth == 64) ? 72 : 39,
    localparam int unsigned SynWidth  = EccWidth - DataWidth,
    localparam int unsigned BeWidth   = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_req_i,
    input  logic [AddrWidth-1:0] in_add_i,
    input  logic                 in_wen_i,
    input  logic [EccWidth-1:0]  in_wdata_i,
    input  logic [BeWidth-1:0]   in_be_i,
    input  logic [IdWidth-1:0]   in_id_i,
    output logic                 in_gnt_o,
    output logic                 in_r_valid_o,
    output logic                 in_r_opc_o,
    output logic [IdWidth-1:0]   in_r_id_o,
    output logic [EccWidth-1:0]  in_r_rdata_o,
    output logic                 out_req_o,
    output logic [AddrWidth-1:0] out_add_o,
    output logic                 out_wen_o,
    output logic [DataWidth-1:0] out_wdata_o,
    output logic [BeWidth-1:0]   out_be_o,
    output logic [IdWidth-1:0]   out_id_o,
    input  logic                 out_gnt_i,
    input  logic                 out_r_valid_i,
    input  logic                 out_r_opc_i,
    input  logic [IdWidth-1:0]   out_r_id_i,
    input  logic [DataWidth-1:0] out_r_rdata_i,
    output logic [SynWidth-1:0]  syndrome_o,
    output logic [1:0]           err_o,
    output logic [AddrWidth-1:0] err_addr_o,
    output logic [CntWidth-1:0]  cnt_corr_o,
    output logic [CntWidth-1:0]  cnt_uncorr_o,
    input  logic                 cnt_clear_i
);

    if (!(DataWidth == 32 || DataWidth == 64)) begin : g_bad_width
        $fatal(1, "pe_xbar_bus_ecc_dec_pipe: DataWidth must be 32 or 64");
    end

    // Hsiao parity rows of prim_secded_39_32 / prim_secded_72_64; check-bit columns are zero.
    function automatic logic [EccWidth-1:0] chk_mask(input int unsigned k);
        logic [71:0] m;
        m = '0;
        if (DataWidth == 64) begin
            case (k)
                0:       m = 72'h00B9000000001FFFFF;
                1:       m = 72'h005E00000FFFE0003F;
                2:       m = 72'h0067003FF003E007C1;
                3:       m = 72'h00CD0FC0F03C207842;
                4:       m = 72'h00B671C711C4438884;
                5:       m = 72'h00B5B65926488C9108;
                6:       m = 72'h00CBDAAA4A91152210;
                7:       m = 72'h007AED348D221A4420;
                default: m = '0;
            endcase
        end else begin
            case (k)
                0:       m = 72'h002606BD25;
                1:       m = 72'h00DEBA8050;
                2:       m = 72'h00413D89AA;
                3:       m = 72'h0031234ED1;
                4:       m = 72'h00C2C1323B;
                5:       m = 72'h002DCC624C;
                6:       m = 72'h0098505586;
                default: m = '0;
            endcase
        end
        return m[EccWidth-1:0];
    endfunction

    function automatic logic [EccWidth-1:0] secded_enc(input logic [DataWidth-1:0] d);
        logic [EccWidth-1:0] cw;
        cw                = '0;
        cw[DataWidth-1:0] = d;
        for (int unsigned k = 0; k < SynWidth; k++) begin
            cw[DataWidth+k] = ^(cw & chk_mask(k));
        end
        return cw;
    endfunction

    function automatic logic [SynWidth-1:0] secded_syn(input logic [EccWidth-1:0] cw);
        logic [SynWidth-1:0] s;
        logic [EccWidth-1:0] own;
        s = '0;
        for (int unsigned k = 0; k < SynWidth; k++) begin
            own              = '0;
            own[DataWidth+k] = 1'b1;
            s[k]             = ^(cw & (chk_mask(k) | own));
        end
        return s;
    endfunction

    // A data bit is flipped when the syndrome equals that bit's parity column.
    function automatic logic [DataWidth-1:0] secded_fix(input logic [EccWidth-1:0] cw,
                                                        input logic [SynWidth-1:0] s);
        logic [DataWidth-1:0] d;
        logic [SynWidth-1:0]  col;
        logic [EccWidth-1:0]  m;
        d = '0;
        for (int unsigned i = 0; i < DataWidth; i++) begin
            col = '0;
            for (int unsigned k = 0; k < SynWidth; k++) begin
                m      = chk_mask(k);
                col[k] = m[i];
            end
            d[i] = cw[i] ^ (s == col);
        end
        return d;
    endfunction

    typedef enum logic {
        ST_IDLE,
        ST_PEND
    } state_e;

    state_e               r_state;
    state_e               w_state_nxt;
    logic                 w_err_pend;
    logic                 w_issue;

    logic                 r_full;
    logic [AddrWidth-1:0] r_add;
    logic                 r_wen;
    logic [DataWidth-1:0] r_wdata;
    logic [BeWidth-1:0]   r_be;
    logic [IdWidth-1:0]   r_id;
    logic [IdWidth-1:0]   r_err_id;
    logic [SynWidth-1:0]  r_syndrome;
    logic [1:0]           r_err;
    logic [AddrWidth-1:0] r_err_addr;
    logic [CntWidth-1:0]  r_cnt_corr;
    logic [CntWidth-1:0]  r_cnt_uncorr;

    logic [SynWidth-1:0]  w_syn;
    logic [DataWidth-1:0] w_dec_data;
    logic [1:0]           w_err;
    logic                 w_accept;
    logic                 w_wr_acc;
    logic                 w_uncorr_acc;
    logic                 w_store;
    logic                 w_drain;

    assign w_syn      = secded_syn(in_wdata_i);
    assign w_dec_data = secded_fix(in_wdata_i, w_syn);
    assign w_err[0]   = ^w_syn;
    assign w_err[1]   = ~w_err[0] & (|w_syn);

    assign in_gnt_o     = ~w_err_pend & (~r_full | out_gnt_i);
    assign w_accept     = in_req_i & in_gnt_o;
    assign w_wr_acc     = w_accept & ~in_wen_i;
    assign w_uncorr_acc = w_wr_acc & w_err[1];
    assign w_store      = w_accept & ~w_uncorr_acc;
    assign w_drain      = r_full & out_gnt_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_uncorr_acc)   w_state_nxt = ST_PEND;
            ST_PEND: if (!out_r_valid_i) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Downstream responses win; the local error response waits for an idle response slot.
    always_comb begin
        w_err_pend = (r_state == ST_PEND);
        w_issue    = (r_state == ST_PEND) & ~out_r_valid_i;
    end

    always_comb begin
        in_r_valid_o = out_r_valid_i;
        in_r_opc_o   = out_r_opc_i;
        in_r_id_o    = out_r_id_i;
        in_r_rdata_o = secded_enc(out_r_rdata_i);
        if (w_issue) begin
            in_r_valid_o = 1'b1;
            in_r_opc_o   = 1'b1;
            in_r_id_o    = r_err_id;
            in_r_rdata_o = secded_enc('0);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_full     <= 1'b0;
            r_add      <= '0;
            r_wen      <= 1'b0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_id       <= '0;
            r_err_id   <= '0;
            r_syndrome <= '0;
            r_err      <= '0;
            r_err_addr <= '0;
        end else begin
            if (w_store) begin
                r_full <= 1'b1;
            end else if (w_drain) begin
                r_full <= 1'b0;
            end
            if (w_store) begin
                r_add   <= in_add_i;
                r_wen   <= in_wen_i;
                r_wdata <= in_wen_i ? '0 : w_dec_data;
                r_be    <= in_be_i;
                r_id    <= in_id_i;
            end
            if (w_wr_acc) begin
                r_syndrome <= w_syn;
                r_err      <= w_err;
            end
            if (w_uncorr_acc) begin
                r_err_addr <= in_add_i;
                r_err_id   <= in_id_i;
            end
        end
    end

    // Clear beats a coincident event; counters stick at all-ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt_corr   <= '0;
            r_cnt_uncorr <= '0;
        end else if (cnt_clear_i) begin
            r_cnt_corr   <= '0;
            r_cnt_uncorr <= '0;
        end else begin
            if (w_wr_acc && w_err[0] && (r_cnt_corr != '1)) begin
                r_cnt_corr <= r_cnt_corr + 1'b1;
            end
            if (w_wr_acc && w_err[1] && (r_cnt_uncorr != '1)) begin
                r_cnt_uncorr <= r_cnt_uncorr + 1'b1;
            end
        end
    end

    assign out_req_o    = r_full;
    assign out_add_o    = r_add;
    assign out_wen_o    = r_wen;
    assign out_wdata_o  = r_wdata;
    assign out_be_o     = r_be;
    assign out_id_o     = r_id;
    assign syndrome_o   = r_syndrome;
    assign err_o        = r_err;
    assign err_addr_o   = r_err_addr;
    assign cnt_corr_o   = r_cnt_corr;
    assign cnt_uncorr_o = r_cnt_uncorr;

endmodule

// File: tb/tb_pe_xbar_bus_ecc_dec_pipe.sv
// Directed bench for pe_xbar_bus_ecc_dec_pipe: a 32-bit instance for the datapath
// and a 64-bit instance with 2-bit counters for saturation/clear.
module tb_pe_xbar_bus_ecc_dec_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int n_checks = 0;
    int n_fail   = 0;

    // SECDED(39,32) codeword of 0xDEADBEEF: check bits [38:32] = 7'h0F
    localparam logic [38:0] CW_BEEF = 39'h0F_DEADBEEF;

    logic        in_req, in_wen, out_gnt, out_r_valid, out_r_opc, cnt_clear;
    logic [31:0] in_add, out_r_rdata;
    logic [38:0] in_wdata;
    logic [3:0]  in_be;
    logic [4:0]  in_id, out_r_id;
    logic        in_gnt, in_r_valid, in_r_opc, out_req, out_wen;
    logic [4:0]  in_r_id, out_id;
    logic [38:0] in_r_rdata;
    logic [31:0] out_add, out_wdata, err_addr;
    logic [3:0]  out_be;
    logic [6:0]  syndrome;
    logic [1:0]  err;
    logic [15:0] cnt_corr, cnt_uncorr;

    logic        in_req64, in_wen64, out_gnt64, out_r_valid64, out_r_opc64, cnt_clear64;
    logic [31:0] in_add64;
    logic [63:0] out_r_rdata64;
    logic [71:0] in_wdata64;
    logic [7:0]  in_be64;
    logic [4:0]  in_id64, out_r_id64;
    logic        in_gnt64, in_r_valid64, in_r_opc64, out_req64, out_wen64;
    logic [4:0]  in_r_id64, out_id64;
    logic [71:0] in_r_rdata64;
    logic [31:0] out_add64, err_addr64;
    logic [63:0] out_wdata64;
    logic [7:0]  out_be64, syndrome64;
    logic [1:0]  err64;
    logic [1:0]  cnt_corr64, cnt_uncorr64;

    pe_xbar_bus_ecc_dec_pipe #(.DataWidth(32)) u_dut32 (
        .clk_i(clk), .rst_ni(rst_n),
        .in_req_i(in_req), .in_add_i(in_add), .in_wen_i(in_wen), .in_wdata_i(in_wdata),
        .in_be_i(in_be), .in_id_i(in_id), .in_gnt_o(in_gnt),
        .in_r_valid_o(in_r_valid), .in_r_opc_o(in_r_opc), .in_r_id_o(in_r_id), .in_r_rdata_o(in_r_rdata),
        .out_req_o(out_req), .out_add_o(out_add), .out_wen_o(out_wen), .out_wdata_o(out_wdata),
        .out_be_o(out_be), .out_id_o(out_id), .out_gnt_i(out_gnt),
        .out_r_valid_i(out_r_valid), .out_r_opc_i(out_r_opc), .out_r_id_i(out_r_id), .out_r_rdata_i(out_r_rdata),
        .syndrome_o(syndrome), .err_o(err), .err_addr_o(err_addr),
        .cnt_corr_o(cnt_corr), .cnt_uncorr_o(cnt_uncorr), .cnt_clear_i(cnt_clear)
    );

    pe_xbar_bus_ecc_dec_pipe #(.DataWidth(64), .CntWidth(2)) u_dut64 (
        .clk_i(clk), .rst_ni(rst_n),
        .in_req_i(in_req64), .in_add_i(in_add64), .in_wen_i(in_wen64), .in_wdata_i(in_wdata64),
        .in_be_i(in_be64), .in_id_i(in_id64), .in_gnt_o(in_gnt64),
        .in_r_valid_o(in_r_valid64), .in_r_opc_o(in_r_opc64), .in_r_id_o(in_r_id64), .in_r_rdata_o(in_r_rdata64),
        .out_req_o(out_req64), .out_add_o(out_add64), .out_wen_o(out_wen64), .out_wdata_o(out_wdata64),
        .out_be_o(out_be64), .out_id_o(out_id64), .out_gnt_i(out_gnt64),
        .out_r_valid_i(out_r_valid64), .out_r_opc_i(out_r_opc64), .out_r_id_i(out_r_id64), .out_r_rdata_i(out_r_rdata64),
        .syndrome_o(syndrome64), .err_o(err64), .err_addr_o(err_addr64),
        .cnt_corr_o(cnt_corr64), .cnt_uncorr_o(cnt_uncorr64), .cnt_clear_i(cnt_clear64)
    );

    task automatic test_reset();
        #12;
        n_checks++; if (out_req !== 1'b0) begin n_fail++; $display("FAIL rst_out_req: got %0b expected 0", out_req); end
        n_checks++; if (out_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_out_wdata: got %h expected 0", out_wdata); end
        n_checks++; if (err !== 2'b00) begin n_fail++; $display("FAIL rst_err: got %b expected 00", err); end
        n_checks++; if (syndrome !== 7'h0) begin n_fail++; $display("FAIL rst_syndrome: got %h expected 0", syndrome); end
        n_checks++; if (err_addr !== 32'h0) begin n_fail++; $display("FAIL rst_err_addr: got %h expected 0", err_addr); end
        n_checks++; if (cnt_corr !== 16'd0 || cnt_uncorr !== 16'd0) begin n_fail++; $display("FAIL rst_cnt: got %0d/%0d expected 0/0", cnt_corr, cnt_uncorr); end
        n_checks++; if (in_r_valid !== 1'b0) begin n_fail++; $display("FAIL rst_r_valid: got %0b expected 0", in_r_valid); end
        n_checks++; if (out_req64 !== 1'b0 || cnt_corr64 !== 2'd0) begin n_fail++; $display("FAIL rst_dut64: got req %0b cnt %0d expected 0/0", out_req64, cnt_corr64); end
        out_r_valid = 1'b1; out_r_id = 5'd3; out_r_rdata = 32'hDEADBEEF;
        #1;
        n_checks++; if (in_r_valid !== 1'b1 || in_r_id !== 5'd3) begin n_fail++; $display("FAIL rst_passthru: got valid %0b id %0d expected 1/3", in_r_valid, in_r_id); end
        n_checks++; if (in_r_rdata !== CW_BEEF) begin n_fail++; $display("FAIL rst_encode: got %h expected %h", in_r_rdata, CW_BEEF); end
        out_r_valid = 1'b0; out_r_id = '0; out_r_rdata = '0;
        #7;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_clean_write();
        in_req = 1'b1; in_wen = 1'b0; in_wdata = CW_BEEF; in_add = 32'h40; in_be = 4'hF; in_id = 5'd2;
        #1;
        n_checks++; if (in_gnt !== 1'b1) begin n_fail++; $display("FAIL clean_gnt: got %0b expected 1", in_gnt); end
        @(posedge clk); #1;
        in_req = 1'b0;
        n_checks++; if (out_req !== 1'b1) begin n_fail++; $display("FAIL clean_req: got %0b expected 1", out_req); end
        n_checks++; if (out_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL clean_wdata: got %h expected deadbeef", out_wdata); end
        n_checks++; if (out_add !== 32'h40 || out_id !== 5'd2 || out_wen !== 1'b0 || out_be !== 4'hF) begin n_fail++; $display("FAIL clean_fields: got add %h id %0d wen %0b be %h expected 40/2/0/f", out_add, out_id, out_wen, out_be); end
        n_checks++; if (err !== 2'b00 || syndrome !== 7'h0) begin n_fail++; $display("FAIL clean_err: got err %b syn %h expected 00/0", err, syndrome); end
        n_checks++; if (cnt_corr !== 16'd0 || cnt_uncorr !== 16'd0) begin n_fail++; $display("FAIL clean_cnt: got %0d/%0d expected 0/0", cnt_corr, cnt_uncorr); end
        @(posedge clk); #1;
        n_checks++; if (out_req !== 1'b0) begin n_fail++; $display("FAIL clean_drain: got %0b expected 0", out_req); end
    endtask

    task automatic test_single_err();
        in_req = 1'b1; in_wen = 1'b0; in_wdata = CW_BEEF ^ 39'h20; in_add = 32'h44; in_id = 5'd4;
        @(posedge clk); #1;
        in_req = 1'b0;
        n_checks++; if (out_req !== 1'b1 || out_wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL sbe_wdata: got req %0b data %h expected 1/deadbeef", out_req, out_wdata); end
        n_checks++; if (err !== 2'b01) begin n_fail++; $display("FAIL sbe_err: got %b expected 01", err); end
        n_checks++; if (syndrome !== 7'h15) begin n_fail++; $display("FAIL sbe_syndrome: got %h expected 15", syndrome); end
        n_checks++; if (cnt_corr !== 16'd1 || cnt_uncorr !== 16'd0) begin n_fail++; $display("FAIL sbe_cnt: got %0d/%0d expected 1/0", cnt_corr, cnt_uncorr); end
        @(posedge clk); #1;
    endtask

    task automatic test_double_err();
        in_req = 1'b1; in_wen = 1'b0; in_wdata = CW_BEEF ^ 39'h20008; in_add = 32'h1000; in_id = 5'd7;
        #1;
        n_checks++; if (in_gnt !== 1'b1) begin n_fail++; $display("FAIL dbe_gnt_before: got %0b expected 1", in_gnt); end
        @(posedge clk); #1;
        in_req = 1'b0;
        n_checks++; if (out_req !== 1'b0) begin n_fail++; $display("FAIL dbe_no_req: got %0b expected 0", out_req); end
        n_checks++; if (in_gnt !== 1'b0) begin n_fail++; $display("FAIL dbe_gnt_pend: got %0b expected 0", in_gnt); end
        n_checks++; if (in_r_valid !== 1'b1 || in_r_opc !== 1'b1 || in_r_id !== 5'd7) begin n_fail++; $display("FAIL dbe_resp: got valid %0b opc %0b id %0d expected 1/1/7", in_r_valid, in_r_opc, in_r_id); end
        n_checks++; if (in_r_rdata !== 39'h0) begin n_fail++; $display("FAIL dbe_rdata: got %h expected 0", in_r_rdata); end
        n_checks++; if (err_addr !== 32'h1000) begin n_fail++; $display("FAIL dbe_err_addr: got %h expected 1000", err_addr); end
        n_checks++; if (err !== 2'b10 || syndrome !== 7'h3F) begin n_fail++; $display("FAIL dbe_err: got err %b syn %h expected 10/3f", err, syndrome); end
        n_checks++; if (cnt_uncorr !== 16'd1 || cnt_corr !== 16'd1) begin n_fail++; $display("FAIL dbe_cnt: got corr %0d uncorr %0d expected 1/1", cnt_corr, cnt_uncorr); end
        @(posedge clk); #1;
        n_checks++; if (in_gnt !== 1'b1 || in_r_valid !== 1'b0) begin n_fail++; $display("FAIL dbe_after: got gnt %0b valid %0b expected 1/0", in_gnt, in_r_valid); end
    endtask

    task automatic test_resp_priority();
        logic [38:0] exp_rd;
        in_req = 1'b1; in_wen = 1'b0; in_wdata = CW_BEEF ^ 39'h20008; in_add = 32'h2000; in_id = 5'd9;
        @(posedge clk); #1;
        in_req = 1'b0;
        out_r_valid = 1'b1; out_r_opc = 1'b0;
        for (int c = 0; c < 3; c++) begin
            out_r_id    = 5'(10 + c);
            out_r_rdata = (c == 1) ? 32'hDEADBEEF : 32'h0;
            exp_rd      = (c == 1) ? CW_BEEF : 39'h0;
            #1;
            n_checks++; if (in_r_valid !== 1'b1 || in_r_opc !== 1'b0 || in_r_id !== 5'(10 + c)) begin n_fail++; $display("FAIL prio_pass%0d: got valid %0b opc %0b id %0d expected 1/0/%0d", c, in_r_valid, in_r_opc, in_r_id, 10 + c); end
            n_checks++; if (in_r_rdata !== exp_rd) begin n_fail++; $display("FAIL prio_rdata%0d: got %h expected %h", c, in_r_rdata, exp_rd); end
            n_checks++; if (in_gnt !== 1'b0) begin n_fail++; $display("FAIL prio_gnt%0d: got %0b expected 0", c, in_gnt); end
            @(posedge clk); #1;
        end
        out_r_valid = 1'b0; out_r_id = '0; out_r_rdata = '0;
        #1;
        n_checks++; if (in_r_valid !== 1'b1 || in_r_opc !== 1'b1 || in_r_id !== 5'd9 || in_r_rdata !== 39'h0) begin n_fail++; $display("FAIL prio_err_resp: got valid %0b opc %0b id %0d data %h expected 1/1/9/0", in_r_valid, in_r_opc, in_r_id, in_r_rdata); end
        @(posedge clk); #1;
        n_checks++; if (in_r_valid !== 1'b0 || in_gnt !== 1'b1) begin n_fail++; $display("FAIL prio_done: got valid %0b gnt %0b expected 0/1", in_r_valid, in_gnt); end
        n_checks++; if (cnt_uncorr !== 16'd2 || err_addr !== 32'h2000) begin n_fail++; $display("FAIL prio_cnt: got uncorr %0d addr %h expected 2/2000", cnt_uncorr, err_addr); end
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int rcvd = 0;
        int done_cyc = -1;
        logic [31:0] held_add = '0;
        logic was_stall = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            out_gnt = !(cyc >= 2 && cyc < 6);
            in_req  = (sent < 8);
            in_wen  = 1'b1;
            in_add  = 32'h100 + 32'(sent);
            in_id   = 5'(sent);
            in_wdata = '0;
            #1;
            if (was_stall) begin
                n_checks++; if (out_add !== held_add) begin n_fail++; $display("FAIL b2b_stable: got %h expected %h", out_add, held_add); end
            end
            if (out_req && out_gnt) begin
                n_checks++; if (out_add !== 32'h100 + 32'(rcvd) || out_id !== 5'(rcvd) || out_wdata !== 32'h0) begin n_fail++; $display("FAIL b2b_item%0d: got add %h id %0d data %h expected %h/%0d/0", rcvd, out_add, out_id, out_wdata, 32'h100 + 32'(rcvd), rcvd); end
                rcvd++;
            end
            if (!out_gnt && out_req) begin
                n_checks++; if (in_gnt !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_gnt: got %0b expected 0", in_gnt); end
                held_add  = out_add;
                was_stall = 1'b1;
            end else begin
                was_stall = 1'b0;
            end
            if (in_req && in_gnt) sent++;
            if (rcvd == 8) begin
                done_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        in_req = 1'b0; out_gnt = 1'b1;
        n_checks++; if (rcvd != 8) begin n_fail++; $display("FAIL b2b_count: got %0d expected 8", rcvd); end
        n_checks++; if (done_cyc != 12) begin n_fail++; $display("FAIL b2b_throughput: got last cycle %0d expected 12", done_cyc); end
        @(posedge clk); #1;
        n_checks++; if (out_req !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %0b expected 0", out_req); end
    endtask

    task automatic test_clear();
        cnt_clear = 1'b1;
        @(posedge clk); #1;
        cnt_clear = 1'b0;
        n_checks++; if (cnt_corr !== 16'd0 || cnt_uncorr !== 16'd0) begin n_fail++; $display("FAIL clear32: got %0d/%0d expected 0/0", cnt_corr, cnt_uncorr); end
    endtask

    task automatic test_cnt_sat64();
        int unsigned flip [7] = '{0, 1, 64, 65, 66, 67, 1};
        int unsigned exp_cnt;
        for (int i = 0; i < 7; i++) begin
            in_req64 = 1'b1; in_wen64 = 1'b0; in_add64 = 32'(i); in_id64 = 5'(i);
            in_wdata64 = '0;
            in_wdata64[flip[i]] = 1'b1;
            cnt_clear64 = (i == 5);
            @(posedge clk); #1;
            in_req64 = 1'b0; cnt_clear64 = 1'b0;
            exp_cnt = (i < 5) ? ((i + 1 > 3) ? 3 : i + 1) : ((i == 5) ? 0 : 1);
            n_checks++; if (cnt_corr64 !== 2'(exp_cnt)) begin n_fail++; $display("FAIL sat64_cnt%0d: got %0d expected %0d", i, cnt_corr64, exp_cnt); end
            n_checks++; if (out_req64 !== 1'b1 || out_wdata64 !== 64'h0 || err64 !== 2'b01) begin n_fail++; $display("FAIL sat64_fix%0d: got req %0b data %h err %b expected 1/0/01", i, out_req64, out_wdata64, err64); end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        in_req = 1'b0; in_wen = 1'b0; in_add = '0; in_wdata = '0; in_be = '0; in_id = '0;
        out_gnt = 1'b1; out_r_valid = 1'b0; out_r_opc = 1'b0; out_r_id = '0; out_r_rdata = '0; cnt_clear = 1'b0;
        in_req64 = 1'b0; in_wen64 = 1'b0; in_add64 = '0; in_wdata64 = '0; in_be64 = 8'hFF; in_id64 = '0;
        out_gnt64 = 1'b1; out_r_valid64 = 1'b0; out_r_opc64 = 1'b0; out_r_id64 = '0; out_r_rdata64 = '0; cnt_clear64 = 1'b0;
        test_reset();
        test_clean_write();
        test_single_err();
        test_double_err();
        test_resp_priority();
        test_back_to_back();
        test_clear();
        test_cnt_sat64();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
